// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - default address / instruction widths and memory depth
//   - HALT opcode value and its bit position inside an instruction word
//   - pc_wrap(): reduce an address modulo the (power-of-two) memory depth
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_INSTR_W   = 16;
    localparam int unsigned DEF_MEM_DEPTH = 128;

    // Opcode field occupies instruction bits [OPC_MSB:OPC_LSB].
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam logic [3:0]  OPC_HALT = 4'b1111;

    // Depth is a power of two, so the modulo is a mask of the low bits.
    function automatic logic [31:0] pc_wrap(input logic [31:0] addr,
                                            input int unsigned depth = DEF_MEM_DEPTH);
        return addr & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Combinational next-PC selection for the fetch stage.
// Priority: redirect target > sequential pc+1 > hold. Every new value is
// wrapped modulo MEM_DEPTH. A load of a HALT word keeps the PC where it is.
//
// Ports:
//   i_pc             current program counter
//   i_redirect_valid branch/jump taken this cycle
//   i_redirect_pc    redirect target (wrapped here)
//   i_load           an instruction is captured this cycle
//   i_halt           the word being loaded is a HALT
//   o_next_pc        PC value for the next cycle
// -----------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_load,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_next_pc
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_next_pc; no latch.
        o_next_pc = i_pc;
        if (i_redirect_valid) begin
            o_next_pc = ADDR_W'(pc_wrap(32'(i_redirect_pc), MEM_DEPTH));
        end else if (i_load && !i_halt) begin
            o_next_pc = ADDR_W'(pc_wrap(32'(i_pc) + 32'd1, MEM_DEPTH));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, drives the asynchronous-read
// instruction memory address, and captures the returned word into an IF/ID
// register handed to the consumer with a valid/ready handshake.
// Supports stall (out_ready low), fetch enable, and redirect with flush.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : a loaded word with opcode 4'b1111 sets halted and freezes the
//               PC; only redirect or reset clears it.
//   undefined : halted is constant 0; opcode 4'b1111 is an ordinary word.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   fetch_en       permits new fetches
//   imem_addr      memory address (combinational copy of the PC)
//   imem_instr     memory read data, valid in the same cycle as imem_addr
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    redirect target
//   out_valid      out_instr/out_pc hold a fetched instruction
//   out_ready      consumer accepts the instruction this cycle
//   out_instr      fetched instruction
//   out_pc         address out_instr was fetched from
//   halted         fetch stopped by a HALT word
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       INSTR_W   = DEF_INSTR_W,
    parameter int unsigned       MEM_DEPTH = DEF_MEM_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_next_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;
    logic               w_load;
    logic               w_is_halt;
    logic               w_halted;

    assign imem_addr = r_pc;

    // Capture only when the output register is empty or being drained.
    assign w_load = fetch_en & ~w_halted & (~r_out_valid | out_ready);

`ifdef FETCH_HALT_EN
    logic r_halted;

    assign w_is_halt = (imem_instr[OPC_MSB:OPC_LSB] == OPC_HALT);
    assign w_halted  = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_load && w_is_halt) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_is_halt = 1'b0;
    assign w_halted  = 1'b0;
`endif

    fetch_pc_gen #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_gen (
        .i_pc             (r_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_load           (w_load),
        .i_halt           (w_is_halt),
        .o_next_pc        (w_next_pc)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (redirect_valid) begin
                // Flush wins over any handshake in flight.
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_instr;
                r_out_pc    <= r_pc;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign halted    = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Two instances: dut (RESET_PC=0) and dut_w (RESET_PC=126, wrap checks).
// Both read one shared behavioural instruction memory. Expected transfers are
// queued as stimulus is set up and popped whenever a handshake is seen.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem [128];

    // dut
    logic        fetch_en, redirect_valid, out_ready;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, halted;

    // dut_w
    logic        w_fetch_en, w_redirect_valid, w_out_ready;
    logic [15:0] w_redirect_pc;
    logic [15:0] w_imem_addr, w_imem_instr, w_out_instr, w_out_pc;
    logic        w_out_valid, w_halted;

    exp_t q[$];
    exp_t q_w[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr   = mem[imem_addr[6:0]];
    assign w_imem_instr = mem[w_imem_addr[6:0]];

    fetch_unit #(.RESET_PC(16'd0)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'd126)) dut_w (
        .clk(clk), .rst(rst), .fetch_en(w_fetch_en),
        .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .halted(w_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        return 16'hA000 ^ 16'(i * 257);
    endfunction

    task automatic push(input int p);
        q.push_back('{pc: 16'(p), instr: mem[p]});
    endtask

    task automatic push_w(input int p);
        q_w.push_back('{pc: 16'(p), instr: mem[p]});
    endtask

    // Called at a negedge with inputs set; scores the handshake that the next
    // posedge will complete, then advances to the following negedge.
    task automatic cycle();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check("sb_pc", 32'(out_pc), 32'(e.pc));
                check("sb_instr", 32'(out_instr), 32'(e.instr));
            end
        end
        if (w_out_valid && w_out_ready) begin
            if (q_w.size() == 0) begin
                check("sbw_underflow", 32'(q_w.size()), 32'd1);
            end else begin
                e = q_w.pop_front();
                check("sbw_pc", 32'(w_out_pc), 32'(e.pc));
                check("sbw_instr", 32'(w_out_instr), 32'(e.instr));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout @%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = word(i);
        rst = 1'b1;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        w_fetch_en = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_addr_w", 32'(w_imem_addr), 32'd126);

        // Wrap from RESET_PC=126, then redirect with upper bits set
        rst = 1'b0;
        w_fetch_en = 1'b1; w_out_ready = 1'b1;
        push_w(126); push_w(127); push_w(0); push_w(1); push_w(5);
        repeat (5) cycle();
        w_out_ready = 1'b0; w_redirect_valid = 1'b1; w_redirect_pc = 16'h0085;
        cycle();
        w_redirect_valid = 1'b0; w_out_ready = 1'b1;
        check("w_flush_valid", 32'(w_out_valid), 32'd0);
        check("w_redir_addr", 32'(w_imem_addr), 32'd5);
        cycle();
        check("w_redir_pc", 32'(w_out_pc), 32'd5);
        w_fetch_en = 1'b0;
        cycle();
        check("w_idle_valid", 32'(w_out_valid), 32'd0);

        // Streaming from 0, then a 3-cycle stall at out_pc=3
        fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(i);
        repeat (4) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", 32'(out_pc), 32'd3);
            check("stall_instr", 32'(out_instr), 32'(word(3)));
            check("stall_addr", 32'(imem_addr), 32'd4);
            cycle();
        end
        out_ready = 1'b1;
        repeat (2) cycle();

        // Redirect to 2 while PC-5 word is stalled: it must never transfer
        check("pre_redir_pc", 32'(out_pc), 32'd5);
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'd2;
        cycle();
        redirect_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'd2);
        out_ready = 1'b1;
        push(2); push(3); push(4);
        cycle();
        check("redir_first_pc", 32'(out_pc), 32'd2);
        repeat (2) cycle();

        // fetch_en low: held word drains, PC freezes, then resumes in order
        fetch_en = 1'b0;
        cycle();
        check("fe0_valid", 32'(out_valid), 32'd0);
        check("fe0_addr", 32'(imem_addr), 32'd5);
        cycle();
        check("fe0_valid2", 32'(out_valid), 32'd0);
        check("fe0_addr2", 32'(imem_addr), 32'd5);
        fetch_en = 1'b1;
        push(5); push(6); push(7);
        cycle();
        check("resume_pc", 32'(out_pc), 32'd5);
        repeat (2) cycle();
        fetch_en = 1'b0;
        cycle();
        check("drain_valid", 32'(out_valid), 32'd0);

        // HALT word at address 3
        mem[3] = 16'hF000;
        fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd0;
        cycle();
        redirect_valid = 1'b0;
        push(0); push(1); push(2); push(3);
`ifndef FETCH_HALT_EN
        push(4);
`endif
        repeat (4) cycle();
`ifdef FETCH_HALT_EN
        check("halt_set", 32'(halted), 32'd1);
        check("halt_pc", 32'(out_pc), 32'd3);
        cycle();
        check("halt_nolo_valid", 32'(out_valid), 32'd0);
        check("halt_addr", 32'(imem_addr), 32'd3);
        cycle();
        check("halt_still", 32'(halted), 32'd1);
        check("halt_still_valid", 32'(out_valid), 32'd0);
        mem[3] = word(3);
        redirect_valid = 1'b1; redirect_pc = 16'd0;
        cycle();
        redirect_valid = 1'b0;
        fetch_en = 1'b0;
        check("halt_clear", 32'(halted), 32'd0);
        check("halt_restart_addr", 32'(imem_addr), 32'd0);
        check("halt_restart_valid", 32'(out_valid), 32'd0);
`else
        check("nohalt_flag", 32'(halted), 32'd0);
        check("nohalt_pc", 32'(out_pc), 32'd3);
        cycle();
        check("nohalt_next", 32'(out_pc), 32'd4);
        fetch_en = 1'b0;
        cycle();
        check("nohalt_drain", 32'(out_valid), 32'd0);
        mem[3] = word(3);
`endif

        check("sb_left", 32'(q.size()), 32'd0);
        check("sbw_left", 32'(q_w.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the memory address, and captures the returned instruction into an IF/ID output register. Consumers take instructions through a valid/ready handshake. The block supports stall, fetch enable and branch redirect with flush.

Parameters:
ADDR_W, 16, width of PC and memory address
INSTR_W, 16, instruction width
MEM_DEPTH, 128, instruction memory depth in words; power of two; PC wraps modulo MEM_DEPTH
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
fetch_en  input  1  permits new fetches when high
imem_addr  output  ADDR_W  address to instruction memory; combinational copy of PC
imem_instr  input  INSTR_W  instruction from memory; asynchronous read, valid in the same cycle as imem_addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  redirect target
out_valid  output  1  out_instr/out_pc hold a fetched instruction
out_ready  input  1  consumer accepts the instruction this cycle
out_instr  output  INSTR_W  fetched instruction
out_pc  output  ADDR_W  address out_instr was fetched from
halted  output  1  fetch stopped by HALT (see Optional Feature)

Behaviour:
- Reset (async, while rst=1): pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0. Fetching begins on the first rising edge after rst falls; memory contents are valid by then.
- imem_addr = pc at all times. There is no registered address.
- Define load = fetch_en & !halted & (!out_valid | out_ready).
- Priority per rising edge is redirect > load > hold.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc mod MEM_DEPTH, i.e. low log2(MEM_DEPTH) bits with upper bits zero.
  - out_valid <= 0, which flushes any held instruction whatever out_ready is.
  - halted <= 0.
  - No load occurs that cycle.
  - The first instruction at the target appears on out_* exactly 1 cycle later, provided fetch_en=1.
- Load:
  - out_instr <= imem_instr, out_pc <= pc, out_valid <= 1.
  - pc <= (pc+1) mod MEM_DEPTH, so MEM_DEPTH-1 wraps to 0.
- No load with out_valid & out_ready (fetch_en=0 or halted): out_valid <= 0, and pc holds.
- No load with out_valid & !out_ready (stall): pc, out_* and out_valid all hold. imem_addr therefore stays stable.
- Throughput is one instruction per cycle when out_ready=1 continuously. Latency is 1 cycle from address to out_*.
- out_instr/out_pc must not change while out_valid=1 and out_ready=0, except when a redirect flushes them.
- Reset asserted mid-stall or mid-redirect overrides everything immediately.

Optional Feature:
Macro FETCH_HALT_EN.
- Defined:
  - An instruction whose bits [15:12] = 4'b1111 (HALT) is loaded normally.
  - On that load, halted <= 1, and pc is not incremented.
  - While halted, no further loads occur; the HALT word still hands off via the handshake.
  - The halted state clears only on redirect or reset.
- Undefined: halted is tied to 0, and opcode 4'b1111 is fetched like any other instruction.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W / INSTR_W defaults
  - OPC_HALT = 4'b1111 and the opcode field position [15:12]
  - a function pc_wrap(addr) giving addr mod MEM_DEPTH
- Sub-module fetch_pc_gen is the natural split. It is combinational next-PC selection (redirect target / pc+1 / hold) with wrap, and takes redirect_valid, load and the halt-detect result.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, mem[0..7] loaded → out_pc 0,1,2,…,7 on consecutive cycles; out_instr equals mem[n]; out_valid high from the first edge after reset.
- out_ready=0 for 3 cycles while out_pc=3 → out_pc/out_instr hold at 3/mem[3], imem_addr holds at 4; after release, out_pc 4 follows next cycle.
- redirect_valid with redirect_pc=2 while out_pc=5 and out_ready=0 → out_valid=0 next cycle, then out_pc=2, then 3; the PC-5 instruction is never transferred.
- Start at RESET_PC=126 → sequence 126, 127, 0, 1; redirect_pc=16'h0085 → pc=5.
- fetch_en=0 mid-stream with out_ready=1 → the held instruction is consumed, out_valid drops, pc frozen; fetch_en=1 resumes at the next sequential PC with no skip or duplicate.
- FETCH_HALT_EN: mem[3]=16'hF000 → out_pc 0..3 delivered, halted=1 after the PC-3 load, no out_pc 4; redirect_pc=0 → halted=0 and fetch restarts at 0. Without the macro, PC 4 follows normally.
